// File: rtl/store_w_gate_pkg.sv
// Shared definitions for the store W gate: AXI channel payload layouts and response codes.
// The channel structs follow the usual AXI field order. Only the fields the gate inspects matter to it.
package store_w_gate_pkg;

  localparam int unsigned DefDataWidth = 128;
  localparam int unsigned DefAddrWidth = 64;
  localparam int unsigned DefUserWidth = 1;
  localparam int unsigned LenWidth     = 8;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [3:0]              id;
    logic [DefAddrWidth-1:0] addr;
    logic [LenWidth-1:0]     len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } aw_chan_t;

  typedef struct packed {
    logic [DefDataWidth-1:0]   data;
    logic [DefDataWidth/8-1:0] strb;
    logic                      last;
    logic [DefUserWidth-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    axi_resp_t resp;
  } b_chan_t;

endpackage

// File: rtl/store_w_gate_len_fifo.sv
// Burst-length FIFO for the store W gate. The head is read straight from storage, so a pushed
// length becomes visible the cycle after its push. Pointers carry an extra wrap bit.
module store_w_gate_len_fifo
  import store_w_gate_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [LenWidth-1:0] push_len,
  input  logic                pop,
  output logic [LenWidth-1:0] head,
  output logic                full,
  output logic                empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  if ((Depth < 2) || ((1 << PtrW) != Depth)) begin : g_bad_depth
    $error("store_w_gate_len_fifo: Depth must be a power of two and at least 2");
  end

  logic [LenWidth-1:0] mem [Depth];
  logic [PtrW:0]       wr_ptr_reg;
  logic [PtrW:0]       rd_ptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop  && !empty) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr_reg[PtrW-1:0]] <= push_len;
  end

  assign head  = mem[rd_ptr_reg[PtrW-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PtrW] != rd_ptr_reg[PtrW]) &&
                 (wr_ptr_reg[PtrW-1:0] == rd_ptr_reg[PtrW-1:0]);

endmodule

// File: rtl/store_w_gate.sv
// Gates store-unit W beats behind their accepted AW bursts, regenerates w.last from the AW length,
// tracks outstanding B responses and reports sticky protocol errors plus an idle flag.
module store_w_gate
  import store_w_gate_pkg::*;
#(
  parameter int unsigned AxiDataWidth  = DefDataWidth,
  parameter int unsigned AxiAddrWidth  = DefAddrWidth,
  parameter int unsigned NrOutstanding = 8,
  parameter type         axi_aw_t      = aw_chan_t,
  parameter type         axi_w_t       = w_chan_t,
  parameter type         axi_b_t       = b_chan_t
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    aw_valid_i,
  output logic    aw_ready_o,
  input  axi_aw_t aw_i,
  output logic    aw_valid_o,
  input  logic    aw_ready_i,
  output axi_aw_t aw_o,
  input  logic    w_valid_i,
  output logic    w_ready_o,
  input  axi_w_t  w_i,
  output logic    w_valid_o,
  input  logic    w_ready_i,
  output axi_w_t  w_o,
  input  logic    b_valid_i,
  output logic    b_ready_o,
  input  axi_b_t  b_i,
  output logic    idle_o,
  output logic    err_o
);

  localparam int unsigned CntW = $clog2(NrOutstanding + 1);

  if (($bits(w_i.data) != AxiDataWidth) || ($bits(aw_i.addr) != AxiAddrWidth) ||
      ($bits(aw_i.len) != LenWidth)) begin : g_bad_width
    $error("store_w_gate: channel struct widths disagree with the width parameters");
  end

  logic                fifo_full;
  logic                fifo_empty;
  logic [LenWidth-1:0] fifo_head;
  logic                aw_hs;
  logic                w_hs;
  logic                last_regen;
  logic [LenWidth-1:0] beat_cnt_reg, beat_cnt_next;
  logic [CntW-1:0]     out_cnt_reg, out_cnt_next;
  logic                err_reg, err_next;

  assign aw_valid_o = aw_valid_i & ~fifo_full;
  assign aw_ready_o = aw_ready_i & ~fifo_full;
  assign aw_o       = aw_i;
  assign aw_hs      = aw_valid_i & aw_ready_i & ~fifo_full;

  assign w_valid_o  = w_valid_i & ~fifo_empty;
  assign w_ready_o  = w_ready_i & ~fifo_empty;
  assign w_hs       = w_valid_i & w_ready_i & ~fifo_empty;
  assign last_regen = (beat_cnt_reg == fifo_head);

  always_comb begin
    w_o      = w_i;
    w_o.last = last_regen;
  end

  assign b_ready_o = 1'b1;
  assign idle_o    = fifo_empty & (out_cnt_reg == '0);
  assign err_o     = err_reg;

  store_w_gate_len_fifo #(
    .Depth (NrOutstanding)
  ) i_len_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (aw_hs),
    .push_len (aw_i.len),
    .pop      (w_hs & last_regen),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    if (w_hs) beat_cnt_next = last_regen ? '0 : beat_cnt_reg + 1'b1;

    // A burst issued and a response returned in the same cycle cancel out; underflow saturates.
    out_cnt_next = out_cnt_reg;
    if (aw_hs && !b_valid_i) begin
      out_cnt_next = out_cnt_reg + 1'b1;
    end else if (!aw_hs && b_valid_i && (out_cnt_reg != '0)) begin
      out_cnt_next = out_cnt_reg - 1'b1;
    end

    err_next = err_reg;
    if (w_hs && (w_i.last != last_regen)) err_next = 1'b1;
    if (b_valid_i && ((b_i.resp != RESP_OKAY) || (out_cnt_reg == '0))) err_next = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_reg <= '0;
      out_cnt_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      beat_cnt_reg <= beat_cnt_next;
      out_cnt_reg  <= out_cnt_next;
      err_reg      <= err_next;
    end
  end

endmodule

// File: tb/tb_store_w_gate.sv
// Self-checking bench for store_w_gate: directed scenarios plus a randomized run compared
// against a queue-based model of pending bursts, beat position, outstanding B count and error flag.
module tb_store_w_gate;
  import store_w_gate_pkg::*;

  localparam int          NR     = 8;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic     clk_i;
  logic     rst_ni;
  logic     aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
  aw_chan_t aw_i, aw_o;
  logic     w_valid_i, w_ready_o, w_valid_o, w_ready_i;
  w_chan_t  w_i, w_o;
  logic     b_valid_i, b_ready_o;
  b_chan_t  b_i;
  logic     idle_o, err_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_q[$];
  int m_beat;
  int m_out;
  bit m_err;

  store_w_gate #(.NrOutstanding(NR)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .aw_valid_i (aw_valid_i),
    .aw_ready_o (aw_ready_o),
    .aw_i       (aw_i),
    .aw_valid_o (aw_valid_o),
    .aw_ready_i (aw_ready_i),
    .aw_o       (aw_o),
    .w_valid_i  (w_valid_i),
    .w_ready_o  (w_ready_o),
    .w_i        (w_i),
    .w_valid_o  (w_valid_o),
    .w_ready_i  (w_ready_i),
    .w_o        (w_o),
    .b_valid_i  (b_valid_i),
    .b_ready_o  (b_ready_o),
    .b_i        (b_i),
    .idle_o     (idle_o),
    .err_o      (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic model_clear();
    m_q.delete();
    m_beat = 0;
    m_out  = 0;
    m_err  = 0;
  endtask

  task automatic drive(input bit awv, input bit awr, input int len, input bit wv, input bit wr,
                       input bit wl, input bit bv, input logic [1:0] resp);
    aw_valid_i  = awv;
    aw_ready_i  = awr;
    aw_i.id     = 4'($urandom());
    aw_i.addr   = {$urandom(), $urandom()};
    aw_i.len    = 8'(len);
    aw_i.size   = 3'd4;
    aw_i.burst  = 2'b01;
    w_valid_i   = wv;
    w_ready_i   = wr;
    w_i.data    = {$urandom(), $urandom(), $urandom(), $urandom()};
    w_i.strb    = 16'($urandom());
    w_i.last    = wl;
    w_i.user    = 1'($urandom());
    b_valid_i   = bv;
    b_i.resp    = resp;
    #1;
  endtask

  // Advance one clock and apply the specification's rules to the model.
  task automatic tick();
    bit aw_hs, w_hs, bv, b_ok, up_last, exp_last;
    int len;
    aw_hs   = aw_valid_i && aw_ready_i && (m_q.size() < NR);
    w_hs    = w_valid_i && w_ready_i && (m_q.size() != 0);
    len     = int'(aw_i.len);
    up_last = w_i.last;
    bv      = b_valid_i;
    b_ok    = (b_i.resp == OKAY);
    @(posedge clk_i);
    #1;
    if (w_hs) begin
      exp_last = (m_beat == m_q[0]);
      if (up_last != exp_last) m_err = 1;
      if (exp_last) begin
        void'(m_q.pop_front());
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    if (aw_hs) m_q.push_back(len);
    if (bv && (!b_ok || m_out == 0)) m_err = 1;
    m_out = m_out + int'(aw_hs) - int'(bv);
    if (m_out < 0) m_out = 0;
  endtask

  task automatic reset_dut();
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, OKAY);
    model_clear();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, OKAY);
    model_clear();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    checks++;
    if ({aw_valid_o, aw_ready_o, w_valid_o, w_ready_o, b_ready_o, idle_o, err_o} !== 7'b0000110) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000110",
               {aw_valid_o, aw_ready_o, w_valid_o, w_ready_o, b_ready_o, idle_o, err_o});
    end
    rst_ni = 1'b1;
    #1;
    $display("test_reset done");
  endtask

  task automatic test_single_burst();
    drive(1, 1, 3, 0, 1, 0, 0, OKAY);
    checks++;
    if (aw_valid_o !== 1'b1 || aw_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL t1_aw_pass got v=%b r=%b exp v=1 r=1", aw_valid_o, aw_ready_o);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1, (i == 3), 0, OKAY);
      checks++;
      if (w_valid_o !== 1'b1 || w_o.last !== 1'(i == 3) || w_o.data !== w_i.data) begin
        errors++;
        $display("FAIL t1_beat%0d got valid=%b last=%b exp valid=1 last=%b", i, w_valid_o, w_o.last, (i == 3));
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, OKAY);
    checks++;
    if (idle_o !== 1'b0) begin
      errors++;
      $display("FAIL t1_busy_until_b got idle=%b exp 0", idle_o);
    end
    drive(0, 0, 0, 0, 0, 0, 1, OKAY);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, OKAY);
    checks++;
    if (idle_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL t1_idle_after_b got idle=%b err=%b exp idle=1 err=0", idle_o, err_o);
    end
    $display("test_single_burst done");
  endtask

  task automatic test_w_before_aw();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1, 0, 0, OKAY);
      checks++;
      if (w_valid_o !== 1'b0 || w_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL t2_held%0d got valid=%b ready=%b exp 0 0", i, w_valid_o, w_ready_o);
      end
      tick();
    end
    drive(1, 1, 3, 1, 1, 0, 0, OKAY);
    checks++;
    if (w_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL t2_same_cycle got w_valid=%b exp 0", w_valid_o);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1, (i == 3), 0, OKAY);
      checks++;
      if (w_valid_o !== 1'b1 || w_o.last !== 1'(i == 3)) begin
        errors++;
        $display("FAIL t2_beat%0d got valid=%b last=%b exp valid=1 last=%b", i, w_valid_o, w_o.last, (i == 3));
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, OKAY);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, OKAY);
    checks++;
    if (idle_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL t2_idle got idle=%b err=%b exp idle=1 err=0", idle_o, err_o);
    end
    $display("test_w_before_aw done");
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < NR; i++) begin
      drive(1, 1, 0, 1, 0, 1, 0, OKAY);
      checks++;
      if (aw_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL t3_fill%0d got aw_ready=%b exp 1", i, aw_ready_o);
      end
      tick();
    end
    drive(1, 1, 0, 1, 0, 1, 0, OKAY);
    checks++;
    if (aw_ready_o !== 1'b0 || aw_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL t3_full got aw_ready=%b aw_valid=%b exp 0 0", aw_ready_o, aw_valid_o);
    end
    tick();
    drive(1, 1, 0, 1, 1, 1, 0, OKAY);
    checks++;
    if (aw_ready_o !== 1'b0 || w_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL t3_pop_cycle got aw_ready=%b w_ready=%b exp 0 1", aw_ready_o, w_ready_o);
    end
    tick();
    drive(1, 1, 0, 1, 0, 1, 0, OKAY);
    checks++;
    if (aw_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL t3_accept_after_pop got aw_ready=%b exp 1", aw_ready_o);
    end
    tick();
    for (int i = 0; i < NR; i++) begin
      drive(0, 0, 0, 1, 1, 1, 1, OKAY);
      checks++;
      if (w_valid_o !== 1'b1 || w_o.last !== 1'b1) begin
        errors++;
        $display("FAIL t3_drain%0d got valid=%b last=%b exp 1 1", i, w_valid_o, w_o.last);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, OKAY);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, OKAY);
    checks++;
    if (idle_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL t3_idle got idle=%b err=%b exp idle=1 err=0", idle_o, err_o);
    end
    $display("test_fifo_full done");
  endtask

  task automatic test_last_mismatch();
    drive(1, 1, 1, 0, 0, 0, 0, OKAY);
    tick();
    drive(0, 0, 0, 1, 1, 1, 0, OKAY);
    checks++;
    if (w_o.last !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL t4_beat0 got last=%b err=%b exp last=0 err=0", w_o.last, err_o);
    end
    tick();
    drive(0, 0, 0, 1, 1, 1, 0, OKAY);
    checks++;
    if (err_o !== 1'b1 || w_valid_o !== 1'b1 || w_o.last !== 1'b1) begin
      errors++;
      $display("FAIL t4_beat1 got err=%b valid=%b last=%b exp 1 1 1", err_o, w_valid_o, w_o.last);
    end
    tick();
    drive(0, 0, 0, 1, 1, 1, 1, OKAY);
    checks++;
    if (w_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL t4_burst_done got w_valid=%b exp 0", w_valid_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, OKAY);
    checks++;
    if (idle_o !== 1'b1 || err_o !== 1'b1) begin
      errors++;
      $display("FAIL t4_sticky got idle=%b err=%b exp idle=1 err=1", idle_o, err_o);
    end
    reset_dut();
    $display("test_last_mismatch done");
  endtask

  task automatic test_b_errors();
    drive(1, 1, 0, 1, 1, 1, 0, OKAY);
    tick();
    drive(0, 0, 0, 1, 1, 1, 0, OKAY);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, SLVERR);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL t5_pre_slverr got err=%b exp 0", err_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, OKAY);
    checks++;
    if (err_o !== 1'b1 || idle_o !== 1'b1) begin
      errors++;
      $display("FAIL t5_slverr got err=%b idle=%b exp err=1 idle=1", err_o, idle_o);
    end
    reset_dut();
    drive(0, 0, 0, 0, 0, 0, 1, OKAY);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, OKAY);
    checks++;
    if (err_o !== 1'b1 || idle_o !== 1'b1) begin
      errors++;
      $display("FAIL t5_unsolicited got err=%b idle=%b exp err=1 idle=1", err_o, idle_o);
    end
    reset_dut();
    $display("test_b_errors done");
  endtask

  task automatic test_reset_mid_burst();
    drive(1, 1, 7, 0, 0, 0, 0, OKAY);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 1, 0, 0, OKAY);
      tick();
    end
    drive(0, 0, 0, 1, 1, 0, 0, OKAY);
    checks++;
    if (w_valid_o !== 1'b1 || w_o.last !== 1'b0) begin
      errors++;
      $display("FAIL t6_beat2 got valid=%b last=%b exp 1 0", w_valid_o, w_o.last);
    end
    rst_ni = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({aw_valid_o, aw_ready_o, w_valid_o, w_ready_o, b_ready_o, idle_o, err_o} !== 7'b0000110) begin
      errors++;
      $display("FAIL t6_async_reset got %b exp 0000110",
               {aw_valid_o, aw_ready_o, w_valid_o, w_ready_o, b_ready_o, idle_o, err_o});
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive(1, 1, 0, 1, 1, 1, 0, OKAY);
    tick();
    drive(0, 0, 0, 1, 1, 1, 0, OKAY);
    checks++;
    if (w_valid_o !== 1'b1 || w_o.last !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL t6_fresh_beat got valid=%b last=%b err=%b exp 1 1 0", w_valid_o, w_o.last, err_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, OKAY);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, OKAY);
    checks++;
    if (idle_o !== 1'b1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL t6_idle got idle=%b err=%b exp idle=1 err=0", idle_o, err_o);
    end
    $display("test_reset_mid_burst done");
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 600; c++) begin
      bit awv, awr, wv, wr, wl, bv, e_full, e_empty, e_last;
      int len;
      logic [1:0] resp;
      awv  = ($urandom_range(0, 2) != 0) && (m_out < NR);
      awr  = ($urandom_range(0, 3) != 0);
      len  = $urandom_range(0, 3);
      wv   = ($urandom_range(0, 3) != 0);
      wr   = ($urandom_range(0, 3) != 0);
      wl   = (m_q.size() > 0) && (m_beat == m_q[0]);
      bv   = (m_out > 0) && ($urandom_range(0, 2) == 0);
      resp = OKAY;
      if (c >= 450) begin
        if ($urandom_range(0, 49) == 0) wl = !wl;
        if ($urandom_range(0, 29) == 0) resp = SLVERR;
      end
      drive(awv, awr, len, wv, wr, wl, bv, resp);
      e_full  = (m_q.size() == NR);
      e_empty = (m_q.size() == 0);
      e_last  = !e_empty && (m_beat == m_q[0]);
      checks++;
      if ({aw_valid_o, aw_ready_o, w_valid_o, w_ready_o} !==
          {awv && !e_full, awr && !e_full, wv && !e_empty, wr && !e_empty}) begin
        errors++;
        $display("FAIL rnd_handshake cycle %0d got %b exp %b", c,
                 {aw_valid_o, aw_ready_o, w_valid_o, w_ready_o},
                 {awv && !e_full, awr && !e_full, wv && !e_empty, wr && !e_empty});
      end
      if (!e_empty) begin
        checks++;
        if (w_o.last !== e_last) begin
          errors++;
          $display("FAIL rnd_last cycle %0d got %b exp %b", c, w_o.last, e_last);
        end
      end
      checks++;
      if (idle_o !== (e_empty && m_out == 0) || err_o !== m_err) begin
        errors++;
        $display("FAIL rnd_status cycle %0d got idle=%b err=%b exp idle=%b err=%b", c,
                 idle_o, err_o, (e_empty && m_out == 0), m_err);
      end
      checks++;
      if (w_o.data !== w_i.data || aw_o !== aw_i) begin
        errors++;
        $display("FAIL rnd_passthrough cycle %0d payload differs from input", c);
      end
      tick();
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, OKAY);
    test_reset();
    test_single_burst();
    test_w_before_aw();
    test_fifo_full();
    test_last_mismatch();
    test_b_errors();
    test_reset_mid_burst();
    reset_dut();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
